// File: rtl/obc_da_mac_seq.sv
// obc_da_mac_seq: bit-serial offset-binary-coded distributed-arithmetic MAC.
// Latches N_TAPS samples, walks one bit-slice per clock MSB first, looks up
// per-group folded OBC LUTs, applies the sign flip and Horner-accumulates
// the slices into a single DFT output term. LUTs and offset are loadable
// while idle.
// Optional build macro OBC_SAT_EN: saturate dout to OUT_W signed range and
// expose sat_flag; without it dout is the wrapped low OUT_W bits.
module obc_da_mac_seq #(
    parameter int N_TAPS = 16,
    parameter int GROUP  = 2,
    parameter int DIN_W  = 16,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 48,
    parameter int OUT_W  = 40,
    localparam int NG    = N_TAPS / GROUP,
    localparam int LD    = 1 << (GROUP - 1),
    localparam int NENT  = NG * LD,
    localparam int CA_W  = (NENT > 1) ? $clog2(NENT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_TAPS*DIN_W-1:0]    in_samples,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           dout,
    input  logic                       cfg_we,
    input  logic [CA_W-1:0]            cfg_addr,
    input  logic [COEF_W-1:0]          cfg_data,
    input  logic                       cfg_off_we,
    input  logic [ACC_W-1:0]           cfg_off,
`ifdef OBC_SAT_EN
    output logic                       sat_flag,
`endif
    output logic                       busy
);

    localparam int JW = (DIN_W > 1) ? $clog2(DIN_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state, state_d;
    logic                      accept;
    logic [N_TAPS*DIN_W-1:0]   smp;
    logic [JW-1:0]             bit_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   off_q;
    logic signed [COEF_W-1:0]  lut [NENT];
    logic [N_TAPS-1:0]         col;
    logic                      msb_slice;
    logic                      last_slice;
    logic signed [ACC_W-1:0]   slice;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [ACC_W-1:0]   fin;
    logic [OUT_W-1:0]          res;
    logic                      ovf;
    logic                      sat_q;

    assign msb_slice  = (bit_cnt == JW'(DIN_W - 1));
    assign last_slice = (bit_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state and handshake outputs; in_ready is held low while in reset
    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Current bit-slice: bit j of every latched sample
    always_comb begin
        logic [DIN_W-1:0] word;
        word = '0;
        col  = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            word   = smp[k*DIN_W +: DIN_W];
            col[k] = word[bit_cnt];
        end
    end

    // Slice sum D_j: folded LUT lookup per group, sign set by lead bit and MSB slice
    always_comb begin
        logic                    f;
        logic [CA_W-1:0]         addr;
        logic signed [ACC_W-1:0] ext;
        f     = 1'b0;
        addr  = '0;
        ext   = '0;
        slice = '0;
        for (int g = 0; g < NG; g++) begin
            f    = col[g*GROUP];
            addr = CA_W'(g * LD);
            for (int i = 1; i < GROUP; i++) addr[i-1] = col[g*GROUP+i] ^ f;
            ext = lut[addr];
            if (f ^ msb_slice) slice = slice - ext;
            else               slice = slice + ext;
        end
    end

    assign acc_nxt = {acc[ACC_W-2:0], 1'b0} + slice;
    assign fin     = acc_nxt + off_q;

`ifdef OBC_SAT_EN
    // Clip when the bits above the OUT_W sign bit are not a pure sign extension
    always_comb begin
        ovf = !((&fin[ACC_W-1:OUT_W-1]) || !(|fin[ACC_W-1:OUT_W-1]));
        res = fin[OUT_W-1:0];
        if (ovf) res = fin[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
    end
    assign sat_flag = sat_q & out_valid;
`else
    assign ovf = 1'b0;
    assign res = fin[OUT_W-1:0];
    generate
        if (ACC_W > OUT_W) begin : g_wrap
            logic unused_hi;
            assign unused_hi = ^fin[ACC_W-1:OUT_W];
        end
    endgenerate
`endif

    // Datapath: sample latch, Horner accumulator, result register, config store
    always_ff @(posedge clk) begin
        if (rst) begin
            smp     <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            dout    <= '0;
            sat_q   <= 1'b0;
            off_q   <= '0;
            for (int e = 0; e < NENT; e++) lut[e] <= '0;
        end else begin
            if (accept) begin
                smp     <= in_samples;
                acc     <= '0;
                bit_cnt <= JW'(DIN_W - 1);
                sat_q   <= 1'b0;
            end
            if (state == RUN) begin
                acc <= acc_nxt;
                if (last_slice) begin
                    dout  <= res;
                    sat_q <= ovf;
                end else begin
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
            // Coefficients only change between vectors; an accept-cycle write
            // lands before the first slice and is used by that vector.
            if (state == IDLE) begin
                if (cfg_we && ({1'b0, cfg_addr} < (CA_W+1)'(NENT)))
                    lut[cfg_addr] <= cfg_data;
                if (cfg_off_we)
                    off_q <= cfg_off;
            end
        end
    end

endmodule

// File: tb/tb_obc_da_mac_seq.sv
// Directed bench for obc_da_mac_seq: N_TAPS=4, GROUP=2, DIN_W=4, OUT_W=8.
module tb_obc_da_mac_seq;

    localparam int N_TAPS = 4;
    localparam int GROUP  = 2;
    localparam int DIN_W  = 4;
    localparam int COEF_W = 32;
    localparam int ACC_W  = 48;
    localparam int OUT_W  = 8;
    localparam int CA_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_TAPS*DIN_W-1:0] in_samples;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        dout;
    logic                    cfg_we;
    logic [CA_W-1:0]         cfg_addr;
    logic [COEF_W-1:0]       cfg_data;
    logic                    cfg_off_we;
    logic [ACC_W-1:0]        cfg_off;
    logic                    busy;
`ifdef OBC_SAT_EN
    logic                    sat_flag;
`endif

    int tests = 0;
    int fails = 0;

    obc_da_mac_seq #(
        .N_TAPS(N_TAPS), .GROUP(GROUP), .DIN_W(DIN_W),
        .COEF_W(COEF_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_samples(in_samples),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_off_we(cfg_off_we), .cfg_off(cfg_off),
`ifdef OBC_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_lut(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = CA_W'(a);
        cfg_data = COEF_W'(d);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic set_off(input longint v);
        cfg_off_we = 1'b1;
        cfg_off    = ACC_W'(v);
        tick();
        cfg_off_we = 1'b0;
    endtask

    task automatic load_default();
        cfg_lut(0, 10);
        cfg_lut(1, 3);
        cfg_lut(2, 5);
        cfg_lut(3, 7);
    endtask

    // Accept one vector, scramble the input bus afterwards, wait for DONE
    task automatic accept_wait(input string tag, input logic [15:0] smp);
        int cyc;
        in_valid   = 1'b1;
        in_samples = smp;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        tick();
        in_valid   = 1'b0;
        cfg_we     = 1'b0;
        in_samples = ~smp;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_nrdy"}, 64'(in_ready), 64'd0);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd5);
    endtask

    task automatic finish_vec(input string tag, input logic [7:0] exp, input logic exp_sat);
        chk({tag, "_dout"}, 64'(dout), 64'(exp));
`ifdef OBC_SAT_EN
        chk({tag, "_sat"}, 64'(sat_flag), 64'(exp_sat));
`else
        if (exp_sat) chk({tag, "_nosat"}, 64'(out_valid), 64'd1);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ovlo"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy2"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_vec(input string tag, input logic [15:0] smp,
                           input logic [7:0] exp, input logic exp_sat);
        accept_wait(tag, smp);
        finish_vec(tag, exp, exp_sat);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_samples = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_off_we = 1'b0; cfg_off = '0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef OBC_SAT_EN
        chk("rst_sat", 64'(sat_flag), 64'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Reset LUT is all zero: result 0
        run_vec("lut_zero", 16'h0000, 8'h00, 1'b0);

        load_default();
        // -15, +15, -2
        run_vec("zeros", 16'h0000, 8'hF1, 1'b0);
        run_vec("ones", 16'hFFFF, 8'h0F, 1'b0);
        run_vec("x0f", 16'h000F, 8'hFE, 1'b0);
        set_off(100);
        run_vec("x0f_off", 16'h000F, 8'h62, 1'b0);
        set_off(0);

        // Backpressure: hold result for 10 cycles
        accept_wait("bp", 16'h0000);
        for (int c = 0; c < 10; c++) begin
            chk("bp_dout", 64'(dout), 64'hF1);
            chk("bp_nrdy", 64'(in_ready), 64'd0);
            chk("bp_ov", 64'(out_valid), 64'd1);
            tick();
        end
        finish_vec("bp", 8'hF1, 1'b0);

        // Config write during RUN is ignored
        begin
            int cyc;
            in_valid = 1'b1; in_samples = 16'h0000;
            tick();
            in_valid = 1'b0;
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'd99;
            tick();
            cfg_we = 1'b0;
            cyc = 2;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("runwr_lat", 64'(cyc), 64'd5);
            finish_vec("runwr", 8'hF1, 1'b0);
        end
        run_vec("runwr_after", 16'h0000, 8'hF1, 1'b0);

        // Write coincident with accept is used: LUT[0]=20 -> -25
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'd20;
        run_vec("acc_wr", 16'h0000, 8'hE7, 1'b0);
        cfg_lut(0, 10);

        // Offset 1000 on zero samples: 985 wraps to 0xD9 or clips to 127
        set_off(1000);
`ifdef OBC_SAT_EN
        run_vec("big_off", 16'h0000, 8'h7F, 1'b1);
`else
        run_vec("big_off", 16'h0000, 8'hD9, 1'b0);
`endif
        set_off(0);

        // Reset on the third RUN cycle
        in_valid = 1'b1; in_samples = 16'h0000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_ov", 64'(out_valid), 64'd0);
        chk("mid_dout", 64'(dout), 64'd0);
        chk("mid_busy0", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rdy", 64'(in_ready), 64'd1);
        run_vec("mid_lutclr", 16'h000F, 8'h00, 1'b0);
        load_default();
        run_vec("mid_new", 16'h000F, 8'hFE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
